// File: rtl/lorenz_frame_tx.sv
// Lorenz x/y/z snapshot serialiser: SYNC_BYTE, x, y, z (MSB byte first), XOR checksum.
// Latency: selected sample_en -> first tx_valid is 1 cycle; a 14-byte frame takes 14 cycles at full rate.
// Backpressure: holds tx_data/tx_valid while tx_ready is low; selected samples arriving mid-frame are dropped and counted.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   sample_en, x/y/z  - integration-step strobe and oscillator state words (n bits each)
//   tx_data/tx_valid/tx_ready - byte stream towards the UART/host link
//   busy              - frame in progress (state machine not IDLE)
//   overrun_cnt       - saturating count of selected samples dropped while busy
module lorenz_frame_tx #(
    parameter int         n         = 32,
    parameter int         DECIM     = 1,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sample_en,
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    input  logic [n-1:0] z,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         busy,
    output logic [7:0]   overrun_cnt
);

    localparam int             NDATA    = 3 * (n / 8);
    localparam int             IW       = $clog2(NDATA);
    localparam logic [IW-1:0]  LAST_IDX = IW'(NDATA - 1);
    localparam logic [IW-1:0]  IDX_ONE  = IW'(1);
    localparam logic [15:0]    DCNT_MAX = 16'(DECIM - 1);

    typedef enum logic [1:0] {IDLE, SYNC, DATA, CSUM} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [15:0]     dcnt;
    logic [n-1:0]    sh_x;
    logic [n-1:0]    sh_y;
    logic [n-1:0]    sh_z;
    logic [7:0]      csum;
    logic [IW-1:0]   idx;

    logic            selected;
    logic            xfer;
    logic            capture;
    logic            drop;
    logic [3*n-1:0]  frame_vec;
    logic [3*n-1:0]  frame_shift;
    logic [7:0]      data_byte;

    // Every non-IDLE state presents a byte, so valid is a pure function of state
    // and the handshake can be derived without looping through tx_valid.
    assign busy     = (state != IDLE);
    assign tx_valid = busy;
    assign xfer     = busy && tx_ready;

    assign selected = sample_en && (dcnt == DCNT_MAX);
    // A sample is taken when idle, or when the checksum byte leaves in the same
    // cycle (back-to-back frame); anywhere else a selected sample is lost.
    assign capture  = selected && ((state == IDLE) || ((state == CSUM) && xfer));
    assign drop     = selected && !capture;

    // Data bytes are walked MSB-first across the concatenated x,y,z snapshot.
    assign frame_vec   = {sh_x, sh_y, sh_z};
    assign frame_shift = frame_vec << {idx, 3'b000};
    assign data_byte   = frame_shift[3*n-1 -: 8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tx_data   = 8'h00;
        case (state)
            IDLE: begin
                if (capture) state_nxt = SYNC;
            end
            SYNC: begin
                tx_data = SYNC_BYTE;
                if (tx_ready) state_nxt = DATA;
            end
            DATA: begin
                tx_data = data_byte;
                if (tx_ready && (idx == LAST_IDX)) state_nxt = CSUM;
            end
            CSUM: begin
                tx_data = csum;
                if (tx_ready) state_nxt = capture ? SYNC : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dcnt        <= 16'h0000;
            sh_x        <= '0;
            sh_y        <= '0;
            sh_z        <= '0;
            csum        <= 8'h00;
            idx         <= '0;
            overrun_cnt <= 8'h00;
        end else begin
            // Decimation runs on every strobe regardless of frame activity.
            if (sample_en) begin
                dcnt <= (dcnt == DCNT_MAX) ? 16'h0000 : dcnt + 16'h0001;
            end

            if (capture) begin
                sh_x <= x;
                sh_y <= y;
                sh_z <= z;
                csum <= 8'h00;
            end else if ((state == DATA) && xfer) begin
                csum <= csum ^ data_byte;
            end

            if ((state == SYNC) && xfer) begin
                idx <= '0;
            end else if ((state == DATA) && xfer) begin
                idx <= idx + IDX_ONE;
            end

            if (drop && (overrun_cnt != 8'hFF)) begin
                overrun_cnt <= overrun_cnt + 8'h01;
            end
        end
    end

endmodule

// File: tb/tb_lorenz_frame_tx.sv
// Bench for lorenz_frame_tx: two instances (DECIM=1 and DECIM=4) share the link-side stimulus.
// Expected frames are built by a byte-level model and queued at strobe time; negedge monitors pop on handshakes.
// Directed steps: reset, basic frame, backpressure, back-to-back, decimation, overrun saturation, reset mid-frame.
module tb_lorenz_frame_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        se1;
    logic        se4;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic        tx_ready;
    logic [7:0]  d1;
    logic [7:0]  d4;
    logic        v1;
    logic        v4;
    logic        b1;
    logic        b4;
    logic [7:0]  ov1;
    logic [7:0]  ov4;

    int total = 0;
    int bad   = 0;
    int rcv4  = 0;

    logic [7:0] exp1[$];
    logic [7:0] exp4[$];

    logic       st1 = 1'b0;
    logic       st4 = 1'b0;
    logic [7:0] hd1 = 8'h00;
    logic [7:0] hd4 = 8'h00;

    always #5 clk = ~clk;

    lorenz_frame_tx #(.n(32), .DECIM(1), .SYNC_BYTE(8'hA5)) dut1 (
        .clk(clk), .rst(rst), .sample_en(se1), .x(x), .y(y), .z(z),
        .tx_data(d1), .tx_valid(v1), .tx_ready(tx_ready),
        .busy(b1), .overrun_cnt(ov1)
    );

    lorenz_frame_tx #(.n(32), .DECIM(4), .SYNC_BYTE(8'hA5)) dut4 (
        .clk(clk), .rst(rst), .sample_en(se4), .x(x), .y(y), .z(z),
        .tx_data(d4), .tx_valid(v4), .tx_ready(tx_ready),
        .busy(b4), .overrun_cnt(ov4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic void put(input int which, input logic [7:0] b);
        if (which == 1) exp1.push_back(b);
        else            exp4.push_back(b);
    endfunction

    // Reference frame: sync byte, 12 data bytes MSB-first, XOR of data bytes only.
    function automatic void push_frame(input int which, input logic [31:0] xv,
                                       input logic [31:0] yv, input logic [31:0] zv);
        logic [95:0] w;
        logic [7:0]  b;
        logic [7:0]  cs;
        w  = {xv, yv, zv};
        cs = 8'h00;
        put(which, 8'hA5);
        for (int i = 0; i < 12; i++) begin
            b  = w[95-8*i -: 8];
            cs = cs ^ b;
            put(which, b);
        end
        put(which, cs);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input bit toggle);
        int c;
        c = 0;
        while ((exp1.size() != 0 || exp4.size() != 0 || v1 || v4) && c < 500) begin
            tx_ready = toggle ? (c % 3 == 0) : 1'b1;
            tick();
            c++;
        end
        tx_ready = 1'b1;
        chk("drain_in_budget", c < 500, 1);
        chk("q1_empty", exp1.size(), 0);
        chk("q4_empty", exp4.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            st1 = 1'b0;
        end else begin
            if (st1) begin
                chk("dut1_valid_hold", v1, 1);
                chk("dut1_data_hold", d1, hd1);
            end
            if (v1 && tx_ready) begin
                chk("dut1_sb_nonempty", exp1.size() > 0, 1);
                if (exp1.size() > 0) chk("dut1_byte", d1, exp1.pop_front());
            end
            st1 = v1 && !tx_ready;
            hd1 = d1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            st4 = 1'b0;
        end else begin
            if (st4) begin
                chk("dut4_valid_hold", v4, 1);
                chk("dut4_data_hold", d4, hd4);
            end
            if (v4 && tx_ready) begin
                chk("dut4_sb_nonempty", exp4.size() > 0, 1);
                if (exp4.size() > 0) begin
                    chk("dut4_byte", d4, exp4.pop_front());
                    rcv4++;
                end
            end
            st4 = v4 && !tx_ready;
            hd4 = d4;
        end
    end

    initial begin
        rst = 1'b1; se1 = 1'b0; se4 = 1'b0;
        x = 32'h0; y = 32'h0; z = 32'h0; tx_ready = 1'b0;
        repeat (3) tick();
        chk("rst_valid1", v1, 0);
        chk("rst_data1", d1, 0);
        chk("rst_busy1", b1, 0);
        chk("rst_ovr1", ov1, 0);
        chk("rst_valid4", v4, 0);
        chk("rst_ovr4", ov4, 0);
        rst = 1'b0;
        repeat (2) tick();

        // Basic frame with unit values; inputs scrambled right after the strobe.
        tx_ready = 1'b1;
        x = 32'h00100000; y = 32'h00100000; z = 32'h00100000;
        push_frame(1, x, y, z);
        se1 = 1'b1;
        tick();
        se1 = 1'b0;
        x = 32'hDEADBEEF; y = 32'hCAFEF00D; z = 32'h0BADC0DE;
        chk("basic_first_valid", v1, 1);
        chk("basic_first_sync", d1, 8'hA5);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk("basic_valid_run", v1, 1);
            tick();
        end
        @(negedge clk);
        chk("basic_end_valid", v1, 0);
        chk("basic_end_busy", b1, 0);
        tick();
        chk("basic_drained", exp1.size(), 0);

        // Backpressure: ready pattern 1,0,0,1,...
        x = 32'h01C00000; y = 32'hFFF00000; z = 32'h12345678;
        push_frame(1, x, y, z);
        se1 = 1'b1;
        tick();
        se1 = 1'b0;
        x = 32'h0;
        drain(1'b1);

        // Back-to-back: second strobe coincides with the checksum handshake.
        tx_ready = 1'b1;
        x = 32'h11111111; y = 32'h22222222; z = 32'h33333333;
        push_frame(1, x, y, z);
        se1 = 1'b1;
        tick();
        se1 = 1'b0;
        repeat (13) tick();
        x = 32'h44444444; y = 32'h55555555; z = 32'h66666666;
        push_frame(1, x, y, z);
        se1 = 1'b1;
        tick();
        se1 = 1'b0;
        x = 32'h0; y = 32'h0; z = 32'h0;
        chk("b2b_valid", v1, 1);
        chk("b2b_sync", d1, 8'hA5);
        chk("b2b_busy", b1, 1);
        chk("b2b_ovr", ov1, 0);
        drain(1'b0);

        // Decimation by 4 on the second instance.
        for (int s = 1; s <= 12; s++) begin
            x = 32'h100 * s; y = 32'h0F0F0000 + s; z = 32'h80000000 | s;
            se4 = 1'b1;
            if (s % 4 == 0) push_frame(4, x, y, z);
            tick();
            se4 = 1'b0;
            x = ~x; y = ~y; z = ~z;
            repeat (19) tick();
        end
        drain(1'b0);
        chk("decim_ovr", ov4, 0);
        chk("decim_bytes", rcv4, 42);

        // Overrun saturation with the link stalled.
        tx_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            x = 32'hA0000000 + i; y = 32'hB0000000 + i; z = 32'hC0000000 + i;
            se1 = 1'b1;
            if (i == 0) push_frame(1, x, y, z);
            tick();
        end
        se1 = 1'b0;
        chk("ovr_sat", ov1, 8'hFF);
        chk("ovr_pending_valid", v1, 1);
        chk("ovr_pending_sync", d1, 8'hA5);
        drain(1'b0);
        chk("ovr_after_drain", ov1, 8'hFF);

        // Asynchronous reset while the fifth data byte is on the link.
        tx_ready = 1'b1;
        x = 32'h11223344; y = 32'h55667788; z = 32'h99AABBCC;
        push_frame(1, x, y, z);
        se1 = 1'b1;
        tick();
        se1 = 1'b0;
        repeat (5) tick();
        chk("rst_mid_byte", d1, 8'h55);
        #3;
        rst = 1'b1;
        exp1.delete();
        #1;
        chk("rst_mid_valid", v1, 0);
        chk("rst_mid_busy", b1, 0);
        chk("rst_mid_ovr", ov1, 0);
        chk("rst_mid_data", d1, 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_no_resume", v1, 0);
        x = 32'hFEDCBA98; y = 32'h76543210; z = 32'h0F1E2D3C;
        push_frame(1, x, y, z);
        se1 = 1'b1;
        tick();
        se1 = 1'b0;
        chk("rst_fresh_valid", v1, 1);
        chk("rst_fresh_sync", d1, 8'hA5);
        drain(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
